// File: rtl/pb_pkg.sv
// Shared types and default constants for the push-button debounce block.
package pb_pkg;

  typedef enum logic [1:0] {
    REL     = 2'd0,
    REL_CHK = 2'd1,
    PRS     = 2'd2,
    PRS_CHK = 2'd3
  } pb_state_e;

  localparam int unsigned DB_CYCLES_DEF   = 250000;
  localparam int unsigned LONG_CYCLES_DEF = 50000000;
  localparam int unsigned CNT_W_DEF       = 26;

endpackage

// File: rtl/pb_debounce_if.sv
// Button bundle: raw active-low pins in, debounced level and event pulses out.
interface pb_debounce_if #(
  parameter int unsigned NUM_BTN = 2
);

  logic [NUM_BTN-1:0] PB_RAW;
  logic [NUM_BTN-1:0] PB_LVL;
  logic [NUM_BTN-1:0] PB_PRESS;
  logic [NUM_BTN-1:0] PB_RELEASE;
  logic [NUM_BTN-1:0] PB_LONG;

  modport master (
    output PB_RAW,
    input  PB_LVL,
    input  PB_PRESS,
    input  PB_RELEASE,
    input  PB_LONG
  );

  modport slave (
    input  PB_RAW,
    output PB_LVL,
    output PB_PRESS,
    output PB_RELEASE,
    output PB_LONG
  );

endinterface

// File: rtl/pb_debounce_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM, hold counter and
// registered level/press/release/long-press outputs.
module pb_debounce_chan
  import pb_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic lvl_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  pb_state_e        state_q;
  logic [CNT_W-1:0] db_cnt_q;
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] hold_d;
  logic             in_prs;
  logic             lvl_q;
  logic             press_q;
  logic             release_q;
  logic             long_q;

  // Plain two-flop synchronizer, idles released (high).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Hold counter runs through bounces while pressed and saturates.
  always_comb begin
    in_prs = (state_q == PRS) || (state_q == PRS_CHK);
    hold_d = hold_q;
    if (in_prs && (hold_q != LONG_MAX)) begin
      hold_d = hold_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= REL;
      db_cnt_q  <= '0;
      hold_q    <= '0;
      lvl_q     <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= hold_d;
      long_q    <= (hold_q != LONG_MAX) && (hold_d == LONG_MAX);
      case (state_q)
        REL: begin
          if (!sync2_q) begin
            state_q  <= REL_CHK;
            db_cnt_q <= CNT_ONE;
          end
        end
        REL_CHK: begin
          if (sync2_q) begin
            state_q  <= REL;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q  <= PRS;
            db_cnt_q <= '0;
            hold_q   <= '0;
            lvl_q    <= 1'b0;
            press_q  <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + CNT_ONE;
          end
        end
        PRS: begin
          if (sync2_q) begin
            state_q  <= PRS_CHK;
            db_cnt_q <= CNT_ONE;
          end
        end
        PRS_CHK: begin
          if (!sync2_q) begin
            state_q  <= PRS;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q   <= REL;
            db_cnt_q  <= '0;
            lvl_q     <= 1'b1;
            release_q <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q  <= REL;
          db_cnt_q <= '0;
        end
      endcase
    end
  end

  assign lvl_o     = lvl_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/pb_debounce.sv
// Push-button conditioning: NUM_BTN independent debounce channels feeding
// the LED display controller.
module pb_debounce
  import pb_pkg::*;
#(
  parameter int unsigned NUM_BTN     = 2,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  pb_debounce_if.slave  pb
);

  logic [NUM_BTN-1:0] lvl_w;
  logic [NUM_BTN-1:0] press_w;
  logic [NUM_BTN-1:0] release_w;
  logic [NUM_BTN-1:0] long_w;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    pb_debounce_chan #(
      .DB_CYCLES   (DB_CYCLES),
      .LONG_CYCLES (LONG_CYCLES),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk_i     (CLK),
      .rst_i     (RESET),
      .raw_i     (pb.PB_RAW[i]),
      .lvl_o     (lvl_w[i]),
      .press_o   (press_w[i]),
      .release_o (release_w[i]),
      .long_o    (long_w[i])
    );
  end

  assign pb.PB_LVL     = lvl_w;
  assign pb.PB_PRESS   = press_w;
  assign pb.PB_RELEASE = release_w;
  assign pb.PB_LONG    = long_w;

endmodule

// File: tb/tb_pb_debounce.sv
// Directed bench for pb_debounce with DB_CYCLES=4, LONG_CYCLES=20, two buttons.
module tb_pb_debounce;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  int   total = 0;
  int   bad   = 0;

  pb_debounce_if #(.NUM_BTN(2)) pb ();

  pb_debounce #(
    .NUM_BTN     (2),
    .DB_CYCLES   (4),
    .LONG_CYCLES (20),
    .CNT_W       (26)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .pb    (pb)
  );

  always #5 CLK = ~CLK;

  // Advance n rising edges, then settle 2 time units past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    pb.PB_RAW = 2'b00;
    #1 RESET = 1'b1;
    #1;
    chk("rst_lvl_async", pb.PB_LVL, 2'b11);
    chk("rst_press_async", pb.PB_PRESS, 2'b00);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("rst_lvl", pb.PB_LVL, 2'b11);
      chk("rst_pulses", pb.PB_PRESS | pb.PB_RELEASE | pb.PB_LONG, 2'b00);
    end
    RESET = 1'b0;
    cyc(5);
    chk("rst_pre_lvl", pb.PB_LVL, 2'b11);
    chk("rst_pre_press", pb.PB_PRESS, 2'b00);
    cyc(1);
    chk("rst_fall_lvl", pb.PB_LVL, 2'b00);
    chk("rst_fall_press", pb.PB_PRESS, 2'b11);
    cyc(1);
    chk("rst_press_once", pb.PB_PRESS, 2'b00);
    pb.PB_RAW = 2'b11;
    cyc(5);
    chk("rst_rel_pre", pb.PB_LVL, 2'b00);
    cyc(1);
    chk("rst_rel_lvl", pb.PB_LVL, 2'b11);
    chk("rst_rel_pulse", pb.PB_RELEASE, 2'b11);
    cyc(1);
    chk("rst_rel_once", pb.PB_RELEASE, 2'b00);
    cyc(2);

    // Single press on button 0.
    pb.PB_RAW = 2'b10;
    cyc(5);
    chk("p0_pre_lvl", pb.PB_LVL, 2'b11);
    chk("p0_pre_press", pb.PB_PRESS, 2'b00);
    cyc(1);
    chk("p0_lvl", pb.PB_LVL, 2'b10);
    chk("p0_press", pb.PB_PRESS, 2'b01);
    cyc(1);
    chk("p0_press_once", pb.PB_PRESS, 2'b00);
    pb.PB_RAW = 2'b11;
    cyc(6);
    chk("p0_rel_lvl", pb.PB_LVL, 2'b11);
    chk("p0_rel_pulse", pb.PB_RELEASE, 2'b01);
    cyc(2);

    // Short bounce (3 cycles) is rejected.
    pb.PB_RAW = 2'b10;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("bnc_lvl", pb.PB_LVL, 2'b11);
    end
    pb.PB_RAW = 2'b11;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("bnc_lvl_after", pb.PB_LVL, 2'b11);
      chk("bnc_pulses", pb.PB_PRESS | pb.PB_RELEASE, 2'b00);
    end

    // Exactly 4 cycles low is accepted, then released.
    pb.PB_RAW = 2'b10;
    cyc(4);
    pb.PB_RAW = 2'b11;
    cyc(2);
    chk("db4_lvl", pb.PB_LVL, 2'b10);
    chk("db4_press", pb.PB_PRESS, 2'b01);
    cyc(3);
    chk("db4_hold_lvl", pb.PB_LVL, 2'b10);
    cyc(1);
    chk("db4_rel_lvl", pb.PB_LVL, 2'b11);
    chk("db4_rel_pulse", pb.PB_RELEASE, 2'b01);
    cyc(2);

    // Long press with a 2-cycle glitch at fall+15.
    pb.PB_RAW = 2'b10;
    cyc(6);
    chk("lp_fall_lvl", pb.PB_LVL, 2'b10);
    chk("lp_fall_press", pb.PB_PRESS, 2'b01);
    for (int i = 0; i < 14; i++) begin
      cyc(1);
      chk("lp_early_long", pb.PB_LONG, 2'b00);
    end
    cyc(1);
    pb.PB_RAW = 2'b11;
    cyc(1);
    chk("lp_glitch_lvl_a", pb.PB_LVL, 2'b10);
    cyc(1);
    pb.PB_RAW = 2'b10;
    chk("lp_glitch_lvl_b", pb.PB_LVL, 2'b10);
    cyc(1);
    chk("lp_glitch_lvl_c", pb.PB_LVL, 2'b10);
    chk("lp_glitch_rel", pb.PB_RELEASE, 2'b00);
    cyc(1);
    chk("lp_pre_long", pb.PB_LONG, 2'b00);
    chk("lp_glitch_lvl_d", pb.PB_LVL, 2'b10);
    cyc(1);
    chk("lp_long", pb.PB_LONG, 2'b01);
    chk("lp_long_lvl", pb.PB_LVL, 2'b10);
    for (int i = 0; i < 13; i++) begin
      cyc(1);
      chk("lp_long_once", pb.PB_LONG, 2'b00);
    end
    pb.PB_RAW = 2'b11;
    cyc(5);
    chk("lp_rel_pre", pb.PB_LVL, 2'b10);
    chk("lp_rel_pre_pulse", pb.PB_RELEASE, 2'b00);
    cyc(1);
    chk("lp_rel_lvl", pb.PB_LVL, 2'b11);
    chk("lp_rel_pulse", pb.PB_RELEASE, 2'b01);
    chk("lp_rel_nolong", pb.PB_LONG, 2'b00);
    cyc(2);

    // Both buttons in the same cycle.
    pb.PB_RAW = 2'b00;
    cyc(6);
    chk("both_lvl", pb.PB_LVL, 2'b00);
    chk("both_press", pb.PB_PRESS, 2'b11);
    cyc(1);
    chk("both_press_once", pb.PB_PRESS, 2'b00);
    pb.PB_RAW = 2'b11;
    cyc(6);
    chk("both_rel_lvl", pb.PB_LVL, 2'b11);
    chk("both_rel_pulse", pb.PB_RELEASE, 2'b11);
    cyc(2);

    // Reset 10 cycles into a held press.
    pb.PB_RAW = 2'b10;
    cyc(6);
    chk("mr_press", pb.PB_PRESS, 2'b01);
    cyc(4);
    chk("mr_held_lvl", pb.PB_LVL, 2'b10);
    #1 RESET = 1'b1;
    #1;
    chk("mr_async_lvl", pb.PB_LVL, 2'b11);
    chk("mr_async_pulses", pb.PB_PRESS | pb.PB_RELEASE | pb.PB_LONG, 2'b00);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("mr_nolong", pb.PB_LONG, 2'b00);
      chk("mr_lvl", pb.PB_LVL, 2'b11);
    end
    RESET = 1'b0;
    cyc(5);
    chk("mr_pre_lvl", pb.PB_LVL, 2'b11);
    chk("mr_pre_press", pb.PB_PRESS, 2'b00);
    cyc(1);
    chk("mr_redet_lvl", pb.PB_LVL, 2'b10);
    chk("mr_redet_press", pb.PB_PRESS, 2'b01);
    cyc(1);
    chk("mr_redet_once", pb.PB_PRESS, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pb_debounce.md
Name: pb_debounce

Overview:
- Push-button conditioning stage, sitting directly upstream of the LED display controller.
- Replaces bare two-flop sampling of active-low board buttons with a synchronizer plus a counter-based debounce per button.
- Outputs clean debounced levels, one-cycle press and release pulses, and a one-cycle long-press pulse.
- The LED controller consumes PB_LVL as its display-select input. The pulses are for future mode-stepping logic.

Parameters:
- NUM_BTN, 2: number of independent button channels.
- DB_CYCLES, 250000: cycles the synchronized input must stay stable before the debounced level changes (5 ms at 50 MHz). Must be at least 2.
- LONG_CYCLES, 50000000: cycles after the debounced press before PB_LONG fires (1 s at 50 MHz). Must be greater than DB_CYCLES.
- CNT_W, 26: width of the debounce and hold counters. Requires LONG_CYCLES < 2^CNT_W.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- PB_RAW  input  NUM_BTN  raw button pins, active-low (0 = depressed), asynchronous to CLK.
- PB_LVL  output  NUM_BTN  debounced level, same polarity as PB_RAW (1 = released).
- PB_PRESS  output  NUM_BTN  one-cycle pulse on debounced 1->0 transition.
- PB_RELEASE  output  NUM_BTN  one-cycle pulse on debounced 0->1 transition.
- PB_LONG  output  NUM_BTN  one-cycle pulse when a press has been held LONG_CYCLES.

Behaviour:
- Reset (asynchronous, immediate): PB_LVL = all 1s; PB_PRESS, PB_RELEASE, PB_LONG = all 0s. Synchronizer flops = 1. Counters = 0. FSM = REL.
- Synchronizer: 2 flops per bit, reset value 1. Let sync[i] denote the second-flop output. No logic sits between the flops.
- Per-channel FSM, 4 states:
  - REL: stable released; PB_LVL = 1. On sync = 0, go to REL_CHK with db_cnt = 1.
  - REL_CHK: if sync = 1, return to REL (db_cnt = 0, no pulse). Else if db_cnt = DB_CYCLES-1, go to PRS. Else increment db_cnt.
  - PRS: stable pressed; PB_LVL = 0. On sync = 1, go to PRS_CHK with db_cnt = 1.
  - PRS_CHK: mirror of REL_CHK. A revert returns to PRS; completion goes to REL.
- Timing of a level change:
  - Let t be the first cycle in which sync differs from PB_LVL.
  - If sync holds the new value for cycles t..t+DB_CYCLES-1, PB_LVL changes at the clock edge ending cycle t+DB_CYCLES-1. It is visible in cycle t+DB_CYCLES.
  - Any shorter excursion produces no level change and no pulse.
- Total pin-to-PB_LVL latency is DB_CYCLES+2 cycles.
- PB_PRESS and PB_RELEASE are registered. Each is high only in the first cycle of the new PB_LVL value.
- Hold counter:
  - Cleared on entry to PRS.
  - Increments in every cycle spent in PRS or PRS_CHK; a bounce during the press does not restart it.
  - Saturates at LONG_CYCLES.
  - PB_LONG pulses for exactly one cycle, in the cycle the counter reaches LONG_CYCLES.
  - At most one PB_LONG per press. Re-armed only by a new PRS entry.
- A release after PB_LONG still produces PB_RELEASE.
- Channels are fully independent:
  - Simultaneous presses and releases on several channels give pulses in the same cycle.
  - No priority between channels.
- No overflow: db_cnt never exceeds DB_CYCLES-1, and the hold counter saturates.
- Reset asserted mid-debounce or mid-hold: all state is lost immediately. After deassertion, a button still held is treated as a new press and re-detected after DB_CYCLES+2 cycles with a fresh PB_PRESS.
- Outputs are glitch-free registered values, safe to use directly in downstream combinational decode.

Decomposition:
- Shared package pb_pkg:
  - state enum {REL, REL_CHK, PRS, PRS_CHK}, 2-bit encoding;
  - default constants for DB_CYCLES, LONG_CYCLES, CNT_W.
- Sub-module pb_debounce_chan: one channel containing synchronizer, FSM, db_cnt, hold counter and registered outputs.
- The top level is a generate loop of NUM_BTN instances.

Test Plan (bench parameters DB_CYCLES=4, LONG_CYCLES=20, NUM_BTN=2):
- Assert RESET for 3 cycles with PB_RAW=2'b00 -> PB_LVL=2'b11 and all pulses 0 during reset. After release, PB_LVL=2'b00 at cycle 6 and PB_PRESS=2'b11 for one cycle.
- From released, drive PB_RAW[0] 1->0 at cycle 0 and hold -> PB_LVL[0]=0 and PB_PRESS[0]=1 in cycle 6 only. PB_LVL[1] stays 1.
- Bounce PB_RAW[0] low for 3 cycles then high -> PB_LVL stays 2'b11 and no pulses. Then low for 4 cycles -> press detected.
- Hold PB_RAW[0] low for 40 cycles with a 2-cycle high glitch at cycle 15 after PB_LVL fall -> PB_LVL unaffected, and PB_LONG[0] pulses once, 20 cycles after PB_LVL fall. On release, PB_RELEASE[0] pulses 6 cycles after the pin rises.
- Press both buttons in the same cycle -> PB_PRESS=2'b11 in one cycle and PB_LVL=2'b00 simultaneously.
- Assert RESET 10 cycles into a held press -> outputs go to released asynchronously with no PB_LONG. After deassertion, PB_PRESS re-fires 6 cycles later.
